demux3w_1to5_reg: RTL and testbench

- Registered 3-bit, 1-to-5 demultiplexer: the distributing counterpart of the 5-to-1 selector.
- On each rising edge of a write strobe, one WIDTH-bit input word is routed into one of five holding registers, selected by a 3-bit code.
- All five registers drive board LEDs continuously.
- Sits between the switch bank and the LED banks on the DE2 lab top level.

---
 rtl/demux3w_1to5_reg_pkg.sv | 17 +
 rtl/demux3w_1to5_reg_edge_detect_rise.sv | 22 ++
 rtl/demux3w_1to5_reg.sv | 130 +++++++++++++
 tb/tb_demux3w_1to5_reg.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/demux3w_1to5_reg_pkg.sv
// Shared constants, FSM encoding and helpers for the registered 1-to-5 demux.
// The optional auto-scan feature is enabled with the DEMUX_SCAN_EN macro.
package demux3w_1to5_reg_pkg;

    localparam int NUM_CH = 5;
    localparam int SEL_W  = 3;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    function automatic logic sel_valid(input logic [SEL_W-1:0] s);
        return s < SEL_W'(NUM_CH);
    endfunction

endpackage

// File: rtl/demux3w_1to5_reg_edge_detect_rise.sv
// One-flop rising-edge detector with async active-low reset.
// A level that is high in the first cycle after reset counts as an edge.
module edge_detect_rise (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

    assign rise = d & ~q;

endmodule

// File: rtl/demux3w_1to5_reg.sv
// Registered 3-bit 1-to-5 demux: wr rising edge routes data_in to channel sel.
// Define DEMUX_SCAN_EN to add the timed auto-scan mode (SCAN state).
module demux3w_1to5_reg
    import demux3w_1to5_reg_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter int SCAN_DIV = 50000000
) (
    input  logic                      CLOCK_50,
    input  logic                      KEY0,
    input  logic [WIDTH-1:0]          data_in,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      wr,
    input  logic                      scan,
    output logic [NUM_CH*WIDTH-1:0]   ch_out,
    output logic [SEL_W-1:0]          last_sel,
    output logic                      wr_ack,
    output logic                      err
);

    logic                     wr_ev;
    logic                     we;
    logic [SEL_W-1:0]         wsel;
    logic                     err_n;
    logic [NUM_CH*WIDTH-1:0]  ch_q;
    logic [SEL_W-1:0]         last_q;
    logic                     ack_q;
    logic                     err_q;
    logic                     tick;

    edge_detect_rise u_wr_edge (
        .clk   (CLOCK_50),
        .rst_n (KEY0),
        .d     (wr),
        .rise  (wr_ev)
    );

`ifdef DEMUX_SCAN_EN
    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
    localparam logic [SEL_W-1:0] PTR_MAX = SEL_W'(NUM_CH - 1);

    state_t            state;
    state_t            state_n;
    logic [CNT_W-1:0]  cnt;
    logic [SEL_W-1:0]  ptr;

    assign tick = (state == SCAN) && scan && (cnt == CNT_MAX);

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (scan)  state_n = SCAN;
            SCAN: if (!scan) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // The pointer advances on every tick, even one dropped for a manual write.
    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            state <= IDLE;
            cnt   <= '0;
            ptr   <= '0;
        end else begin
            state <= state_n;
            if ((state == SCAN) && scan) begin
                cnt <= tick ? '0 : cnt + 1'b1;
                if (tick) begin
                    ptr <= (ptr == PTR_MAX) ? '0 : ptr + 1'b1;
                end
            end else begin
                cnt <= '0;
                ptr <= '0;
            end
        end
    end
`else
    logic unused_cfg;

    assign tick       = 1'b0;
    assign unused_cfg = scan ^ (SCAN_DIV < 2);
`endif

    always_comb begin
        we    = 1'b0;
        wsel  = '0;
        err_n = err_q;
        if (wr_ev) begin
            if (sel_valid(sel)) begin
                we    = 1'b1;
                wsel  = sel;
                err_n = 1'b0;
            end else begin
                err_n = 1'b1;
            end
        end else if (tick) begin
            we = 1'b1;
`ifdef DEMUX_SCAN_EN
            wsel = ptr;
`endif
        end
    end

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            ch_q   <= '0;
            last_q <= '0;
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (we && (wsel == SEL_W'(k))) begin
                    ch_q[k*WIDTH +: WIDTH] <= data_in;
                end
            end
            if (we) begin
                last_q <= wsel;
            end
            ack_q <= we;
            err_q <= err_n;
        end
    end

    assign ch_out   = ch_q;
    assign last_sel = last_q;
    assign wr_ack   = ack_q;
    assign err      = err_q;

endmodule

// File: tb/tb_demux3w_1to5_reg.sv
// Scoreboard bench for demux3w_1to5_reg: each accepted write pushes its
// expected {last_sel, ch_out}; a negedge monitor pops on every wr_ack.
module tb_demux3w_1to5_reg;

    localparam int W   = 3;
    localparam int NCH = 5;

    typedef struct packed {
        logic [2:0]  ls;
        logic [14:0] ch;
    } exp_t;

    logic        clk = 1'b0;
    logic        key0 = 1'b0;
    logic [2:0]  data_in = '0;
    logic [2:0]  sel = '0;
    logic        wr = 1'b0;
    logic        scan = 1'b0;
    logic [14:0] ch_out;
    logic [2:0]  last_sel;
    logic        wr_ack;
    logic        err;

    exp_t        q[$];
    logic [2:0]  m_ch[NCH];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    demux3w_1to5_reg #(.WIDTH(W), .SCAN_DIV(4)) dut (
        .CLOCK_50 (clk),
        .KEY0     (key0),
        .data_in  (data_in),
        .sel      (sel),
        .wr       (wr),
        .scan     (scan),
        .ch_out   (ch_out),
        .last_sel (last_sel),
        .wr_ack   (wr_ack),
        .err      (err)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, req);
        end
    endtask

    function automatic logic [14:0] packm();
        return {m_ch[4], m_ch[3], m_ch[2], m_ch[1], m_ch[0]};
    endfunction

    task automatic push(input logic [2:0] s, input logic [2:0] d);
        exp_t e;
        m_ch[s] = d;
        e.ls = s;
        e.ch = packm();
        q.push_back(e);
    endtask

    task automatic clr_model();
        for (int k = 0; k < NCH; k++) m_ch[k] = '0;
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [2:0] s, input logic [2:0] d);
        sel = s;
        data_in = d;
        wr = 1'b1;
        tick();
        wr = 1'b0;
        tick();
    endtask

    task automatic wr_valid(input logic [2:0] s, input logic [2:0] d);
        push(s, d);
        pulse(s, d);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (key0 && wr_ack === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack got sel %0d want none", last_sel);
            end else begin
                e = q.pop_front();
                chk("ack_ch_out", 32'(ch_out), 32'(e.ch));
                chk("ack_last_sel", 32'(last_sel), 32'(e.ls));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end

    initial begin
        clr_model();
        tick(2);
        chk("rst_ch_out", 32'(ch_out), 32'h0);
        chk("rst_last_sel", 32'(last_sel), 32'h0);
        chk("rst_wr_ack", 32'(wr_ack), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        key0 = 1'b1;
        tick();

        wr_valid(3'd2, 3'b101);
        chk("sel2_ch_out", 32'(ch_out), 32'(15'b000_000_101_000_000));
        chk("sel2_last_sel", 32'(last_sel), 32'd2);
        chk("ack_one_cycle", 32'(wr_ack), 32'h0);

        push(3'd0, 3'd1);
        sel = 3'd0;
        wr = 1'b1;
        for (int i = 0; i < 10; i++) begin
            data_in = 3'(i + 1);
            tick();
        end
        wr = 1'b0;
        tick();
        chk("held_wr_ch_out", 32'(ch_out), 32'(packm()));

        pulse(3'd6, 3'b111);
        chk("bad_sel_err", 32'(err), 32'h1);
        chk("bad_sel_ch_out", 32'(ch_out), 32'(packm()));
        tick(3);
        chk("err_sticky", 32'(err), 32'h1);
        wr_valid(3'd4, 3'b011);
        chk("err_cleared", 32'(err), 32'h0);
        chk("ch4_value", 32'(ch_out[14:12]), 32'(3'b011));

        for (int k = 0; k < NCH; k++) wr_valid(3'(k), 3'(k + 1));
        chk("fill_all", 32'(ch_out), 32'(15'b101_100_011_010_001));
        wr_valid(3'd4, 3'd5);
        chk("rewrite_same", 32'(ch_out), 32'(15'b101_100_011_010_001));

        pulse(3'd7, 3'd0);
        chk("sel7_err", 32'(err), 32'h1);
        pulse(3'd5, 3'd0);
        chk("sel5_err", 32'(err), 32'h1);
        chk("sel5_last_sel", 32'(last_sel), 32'd4);

        for (int k = 0; k < NCH; k++) wr_valid(3'(k), 3'b111);
        chk("all_ones", 32'(ch_out), 32'h7fff);
        pulse(3'd6, 3'd0);
        sel = 3'd1;
        data_in = 3'b010;
        wr = 1'b1;
        @(posedge clk);
        #2;
        key0 = 1'b0;
        #1;
        chk("async_rst_ch_out", 32'(ch_out), 32'h0);
        chk("async_rst_err", 32'(err), 32'h0);
        chk("async_rst_ack", 32'(wr_ack), 32'h0);
        chk("async_rst_last", 32'(last_sel), 32'h0);
        clr_model();
        push(3'd1, 3'b010);
        @(negedge clk);
        #1;
        key0 = 1'b1;
        tick();
        wr = 1'b0;
        tick();
        chk("first_edge_after_rst", 32'(ch_out), 32'(15'b000_000_000_010_000));

`ifdef DEMUX_SCAN_EN
        data_in = 3'b110;
        sel = 3'd0;
        scan = 1'b1;
        for (int i = 0; i < 6; i++) push(3'(i % NCH), 3'b110);
        tick(25);
        scan = 1'b0;
        tick(2);
        chk("scan_fill", 32'(ch_out), 32'(15'b110_110_110_110_110));
        chk("scan_wrap_sel", 32'(last_sel), 32'd0);

        data_in = 3'b010;
        scan = 1'b1;
        push(3'd0, 3'b010);
        tick(8);
        push(3'd3, 3'b001);
        sel = 3'd3;
        data_in = 3'b001;
        wr = 1'b1;
        tick();
        wr = 1'b0;
        data_in = 3'b010;
        push(3'd2, 3'b010);
        tick(4);
        scan = 1'b0;
        tick(2);
        chk("scan_collide", 32'(ch_out), 32'(15'b110_001_010_110_010));
        chk("scan_collide_sel", 32'(last_sel), 32'd2);
`endif

        tick(3);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
